pn_ctrl: RTL and testbench

- Buffer-pool controller for the packet filter core, generalising the fixed three-buffer rotation controller to NUM_BUFS packet buffers.
- Hands buffers in turn to three agents:
  - snooper (A) fills a buffer;
  - CPU (B) accepts or rejects it;
  - forwarder (C) drains it.
- Uses in-order FIFO queues between stages.
- Drives per-agent buffer indices and per-buffer owner selects for the mux fabric.

---
 rtl/pn_ctrl_pkg.sv | 31 +++
 rtl/pn_ctrl_if.sv | 41 ++++
 rtl/pn_idx_fifo.sv | 52 +++++
 rtl/pn_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pn_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pn_ctrl_pkg.sv
// Shared types for the packet-buffer pool controller: mux owner codes, agent FSM states,
// and the index-width helper.
package pn_ctrl_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_SN   = 2'b01,
      OWN_CPU  = 2'b10,
      OWN_FWD  = 2'b11
   } owner_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_BUSY  = 2'd2
   } agent_state_t;

   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Agent 0 is the snooper, 1 the CPU, 2 the forwarder.
   function automatic owner_t agent_owner(input int k);
      case (k)
         0:       return OWN_SN;
         1:       return OWN_CPU;
         default: return OWN_FWD;
      endcase
   endfunction

endpackage

// File: rtl/pn_ctrl_if.sv
// Agent handshakes and mux-fabric status of the buffer-pool controller.
// The controller takes the slave modport; the agents (or a bench) take the master side.
interface pn_ctrl_if #(
   parameter int NUM_BUFS  = 4,
   parameter int SEL_WIDTH = pn_ctrl_pkg::sel_width(NUM_BUFS),
   parameter int CNT_WIDTH = 32
);
   logic                   A_done;
   logic                   A_done_ack;
   logic                   rdy_for_A;
   logic                   rdy_for_A_ack;
   logic                   B_acc;
   logic                   B_rej;
   logic                   B_done_ack;
   logic                   rdy_for_B;
   logic                   rdy_for_B_ack;
   logic                   C_done;
   logic                   C_done_ack;
   logic                   rdy_for_C;
   logic                   rdy_for_C_ack;
   logic [SEL_WIDTH-1:0]   sn_sel;
   logic [SEL_WIDTH-1:0]   cpu_sel;
   logic [SEL_WIDTH-1:0]   fwd_sel;
   logic [2*NUM_BUFS-1:0]  buf_sel;
   logic [SEL_WIDTH:0]     free_cnt;
   logic [SEL_WIDTH:0]     cpu_q_cnt;
   logic [SEL_WIDTH:0]     fwd_q_cnt;
   logic [CNT_WIDTH-1:0]   drop_cnt;

   modport slave (
      input  A_done, rdy_for_A_ack, B_acc, B_rej, rdy_for_B_ack, C_done, rdy_for_C_ack,
      output A_done_ack, rdy_for_A, B_done_ack, rdy_for_B, C_done_ack, rdy_for_C,
             sn_sel, cpu_sel, fwd_sel, buf_sel, free_cnt, cpu_q_cnt, fwd_q_cnt, drop_cnt
   );

   modport master (
      output A_done, rdy_for_A_ack, B_acc, B_rej, rdy_for_B_ack, C_done, rdy_for_C_ack,
      input  A_done_ack, rdy_for_A, B_done_ack, rdy_for_B, C_done_ack, rdy_for_C,
             sn_sel, cpu_sel, fwd_sel, buf_sel, free_cnt, cpu_q_cnt, fwd_q_cnt, drop_cnt
   );
endinterface

// File: rtl/pn_idx_fifo.sv
// Circular FIFO of buffer indices with two ordered write ports (wr0 lands before wr1)
// and one read port; INIT_FULL preloads 0..DEPTH-1 at reset.
module pn_idx_fifo
   import pn_ctrl_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int W         = sel_width(DEPTH),
   parameter bit INIT_FULL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr0_en,
   input  logic [W-1:0] wr0_data,
   input  logic         wr1_en,
   input  logic [W-1:0] wr1_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic [W:0]   cnt
);
   localparam int CW = W + 1;

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic [W-1:0] tail_mid;

   function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + W'(1);
   endfunction

   assign tail_mid = wr0_en ? wrap_inc(tail) : tail;
   assign rd_data  = mem[head];

   // A full FIFO has tail wrapped back onto head, so both pointers reset to 0 either way.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= INIT_FULL ? CW'(DEPTH) : '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= INIT_FULL ? W'(i) : '0;
         end
      end else begin
         if (wr0_en) mem[tail]     <= wr0_data;
         if (wr1_en) mem[tail_mid] <= wr1_data;
         if (rd_en)  head          <= wrap_inc(head);
         tail <= wr1_en ? wrap_inc(tail_mid) : tail_mid;
         cnt  <= cnt + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
      end
   end

endmodule

// File: rtl/pn_ctrl.sv
// Buffer-pool controller: rotates NUM_BUFS packet buffers snooper -> CPU -> forwarder via index FIFOs.
// Build option PN_CTRL_OVERWRITE_EN lets a starved snooper reclaim the oldest unread CPU buffer.
//
// state    | meaning
// ST_IDLE  | agent holds no buffer, waits for its source queue to be non-empty
// ST_OFFER | head index popped into X_sel, rdy_for_X high until rdy_for_X_ack
// ST_BUSY  | agent works on X_sel until its done, then the buffer is released
module pn_ctrl
   import pn_ctrl_pkg::*;
#(
   parameter int NUM_BUFS  = 4,
   parameter int SEL_WIDTH = sel_width(NUM_BUFS),
   parameter int CNT_WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   pn_ctrl_if.slave bus
);
   // Agent k pops from queue k: 0 free->snooper, 1 cpu->CPU, 2 fwd->forwarder.
   localparam int NQ = 3;
   localparam int QW = SEL_WIDTH + 1;

   agent_state_t          st     [NQ];
   agent_state_t          st_nxt [NQ];
   logic [SEL_WIDTH-1:0]  sel     [NQ];
   logic [SEL_WIDTH-1:0]  sel_nxt [NQ];
   logic [NQ-1:0]         rdy, rdy_nxt;
   logic [NQ-1:0]         ack, ack_nxt;
   logic [NQ-1:0]         alloc;
   logic [2*NUM_BUFS-1:0] buf_sel, buf_sel_nxt;
   logic [CNT_WIDTH-1:0]  drop_cnt, drop_nxt;
   logic                  ovw;

   logic [NQ-1:0]         take;
   logic [NQ-1:0]         done;
   logic [SEL_WIDTH-1:0]  q_head     [NQ];
   logic [QW-1:0]         q_cnt      [NQ];
   logic [NQ-1:0]         q_pop, q_wr0, q_wr1;
   logic [SEL_WIDTH-1:0]  q_wr0_data [NQ];
   logic [SEL_WIDTH-1:0]  q_wr1_data [NQ];

   assign take = {bus.rdy_for_C_ack, bus.rdy_for_B_ack, bus.rdy_for_A_ack};
   assign done = {bus.C_done, bus.B_acc | bus.B_rej, bus.A_done};

   for (genvar k = 0; k < NQ; k++) begin : g_q
      pn_idx_fifo #(
         .DEPTH     (NUM_BUFS),
         .W         (SEL_WIDTH),
         .INIT_FULL (k == 0)
      ) u_q (
         .clk      (clk),
         .rst      (rst),
         .wr0_en   (q_wr0[k]),
         .wr0_data (q_wr0_data[k]),
         .wr1_en   (q_wr1[k]),
         .wr1_data (q_wr1_data[k]),
         .rd_en    (q_pop[k]),
         .rd_data  (q_head[k]),
         .cnt      (q_cnt[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NQ; k++) begin
            st[k]  <= ST_IDLE;
            sel[k] <= '0;
         end
         rdy      <= '0;
         ack      <= '0;
         buf_sel  <= '0;
         drop_cnt <= '0;
      end else begin
         for (int k = 0; k < NQ; k++) begin
            st[k]  <= st_nxt[k];
            sel[k] <= sel_nxt[k];
         end
         rdy      <= rdy_nxt;
         ack      <= ack_nxt;
         buf_sel  <= buf_sel_nxt;
         drop_cnt <= drop_nxt;
      end
   end

   always_comb begin
      q_pop = '0;
      q_wr0 = '0;
      q_wr1 = '0;
      alloc = '0;
      ovw   = 1'b0;
      for (int k = 0; k < NQ; k++) begin
         st_nxt[k]     = st[k];
         q_wr0_data[k] = '0;
         q_wr1_data[k] = '0;
         unique case (st[k])
            ST_IDLE: begin
               if (q_cnt[k] != '0) begin
                  st_nxt[k] = ST_OFFER;
                  q_pop[k]  = 1'b1;
                  alloc[k]  = 1'b1;
               end
            end
            ST_OFFER: if (take[k]) st_nxt[k] = ST_BUSY;
            ST_BUSY:  if (done[k]) st_nxt[k] = ST_IDLE;
            default:  st_nxt[k] = ST_IDLE;
         endcase
      end
`ifdef PN_CTRL_OVERWRITE_EN
      // The cpu queue has one read port; an idle CPU popping it this cycle wins.
      if (st[0] == ST_IDLE && q_cnt[0] == '0 && q_cnt[1] != '0 && !q_pop[1]) begin
         st_nxt[0] = ST_OFFER;
         q_pop[1]  = 1'b1;
         alloc[0]  = 1'b1;
         ovw       = 1'b1;
      end
`endif
      if (st[0] == ST_BUSY && done[0]) begin
         q_wr0[1]      = 1'b1;
         q_wr0_data[1] = sel[0];
      end
      // A reject wins over a simultaneous accept; B's free push is ordered ahead of C's.
      if (st[1] == ST_BUSY && done[1]) begin
         if (bus.B_rej) begin
            q_wr0[0]      = 1'b1;
            q_wr0_data[0] = sel[1];
         end else begin
            q_wr0[2]      = 1'b1;
            q_wr0_data[2] = sel[1];
         end
      end
      if (st[2] == ST_BUSY && done[2]) begin
         q_wr1[0]      = 1'b1;
         q_wr1_data[0] = sel[2];
      end
   end

   always_comb begin
      buf_sel_nxt = buf_sel;
      for (int k = 0; k < NQ; k++) begin
         rdy_nxt[k] = (st_nxt[k] == ST_OFFER);
         ack_nxt[k] = (st[k] == ST_BUSY) && done[k];
         sel_nxt[k] = alloc[k] ? q_head[k] : sel[k];
         if (ack_nxt[k]) buf_sel_nxt[2*int'(sel[k]) +: 2] = OWN_NONE;
      end
      if (ovw) sel_nxt[0] = q_head[1];
      for (int k = 0; k < NQ; k++) begin
         if (alloc[k]) buf_sel_nxt[2*int'(sel_nxt[k]) +: 2] = agent_owner(k);
      end
`ifdef PN_CTRL_OVERWRITE_EN
      drop_nxt = (ovw && !(&drop_cnt)) ? drop_cnt + CNT_WIDTH'(1) : drop_cnt;
`else
      drop_nxt = '0;
`endif
   end

   assign bus.rdy_for_A  = rdy[0];
   assign bus.rdy_for_B  = rdy[1];
   assign bus.rdy_for_C  = rdy[2];
   assign bus.A_done_ack = ack[0];
   assign bus.B_done_ack = ack[1];
   assign bus.C_done_ack = ack[2];
   assign bus.sn_sel     = sel[0];
   assign bus.cpu_sel    = sel[1];
   assign bus.fwd_sel    = sel[2];
   assign bus.buf_sel    = buf_sel;
   assign bus.free_cnt   = q_cnt[0];
   assign bus.cpu_q_cnt  = q_cnt[1];
   assign bus.fwd_q_cnt  = q_cnt[2];
   assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_pn_ctrl.sv
// Bench for pn_ctrl: directed handshake sequences plus randomized agent behaviour,
// every cycle compared against a queue-based model of the buffer rotation.
module tb_pn_ctrl;
   localparam int NB = 4;
   localparam int SW = 2;
   localparam int P_IDLE  = 0;
   localparam int P_OFFER = 1;
   localparam int P_BUSY  = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   int     fq[$];
   int     cq[$];
   int     wq[$];
   int     ph  [3];
   int     idx [3];
   bit     ack_e [3];
   longint drops;

   pn_ctrl_if #(.NUM_BUFS(NB), .SEL_WIDTH(SW), .CNT_WIDTH(32)) bus ();

   pn_ctrl #(.NUM_BUFS(NB), .SEL_WIDTH(SW), .CNT_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic bit pr(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   task automatic drive(input bit a_tk, input bit a_dn, input bit b_tk, input bit b_acc,
                        input bit b_rej, input bit c_tk, input bit c_dn);
      bus.rdy_for_A_ack = a_tk;
      bus.A_done        = a_dn;
      bus.rdy_for_B_ack = b_tk;
      bus.B_acc         = b_acc;
      bus.B_rej         = b_rej;
      bus.rdy_for_C_ack = c_tk;
      bus.C_done        = c_dn;
   endtask

   task automatic model_reset();
      fq = {0, 1, 2, 3};
      cq = {};
      wq = {};
      for (int k = 0; k < 3; k++) begin
         ph[k]    = P_IDLE;
         idx[k]   = 0;
         ack_e[k] = 1'b0;
      end
      drops = 0;
   endtask

   function automatic int pop_src(input int k);
      if (k == 0) return fq.pop_front();
      if (k == 1) return cq.pop_front();
      return wq.pop_front();
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_update();
      int sz [3];
      bit tk [3];
      bit dn [3];
      bit rel [3];
      bit ovw;
      if (rst) begin
         model_reset();
         return;
      end
      sz[0] = fq.size();
      sz[1] = cq.size();
      sz[2] = wq.size();
      tk[0] = bus.rdy_for_A_ack;
      tk[1] = bus.rdy_for_B_ack;
      tk[2] = bus.rdy_for_C_ack;
      dn[0] = bus.A_done;
      dn[1] = bus.B_acc | bus.B_rej;
      dn[2] = bus.C_done;
      ovw = 1'b0;
`ifdef PN_CTRL_OVERWRITE_EN
      ovw = (ph[0] == P_IDLE) && (sz[0] == 0) && (sz[1] > 0) && (ph[1] != P_IDLE);
`endif
      for (int k = 0; k < 3; k++) begin
         rel[k]   = 1'b0;
         ack_e[k] = 1'b0;
         if (ph[k] == P_IDLE) begin
            if (sz[k] > 0) begin
               ph[k]  = P_OFFER;
               idx[k] = pop_src(k);
            end else if (k == 0 && ovw) begin
               ph[0]  = P_OFFER;
               idx[0] = cq.pop_front();
               if (drops < 64'hFFFF_FFFF) drops++;
            end
         end else if (ph[k] == P_OFFER) begin
            if (tk[k]) ph[k] = P_BUSY;
         end else if (dn[k]) begin
            ph[k]    = P_IDLE;
            rel[k]   = 1'b1;
            ack_e[k] = 1'b1;
         end
      end
      if (rel[0]) cq.push_back(idx[0]);
      if (rel[1]) begin
         if (bus.B_rej) fq.push_back(idx[1]);
         else           wq.push_back(idx[1]);
      end
      if (rel[2]) fq.push_back(idx[2]);
   endtask

   function automatic logic [2*NB-1:0] exp_buf_sel();
      logic [2*NB-1:0] v;
      v = '0;
      for (int b = 0; b < NB; b++) begin
         for (int k = 0; k < 3; k++) begin
            if (ph[k] != P_IDLE && idx[k] == b) v[2*b +: 2] = 2'(k + 1);
         end
      end
      return v;
   endfunction

   task automatic check_all();
      chk("rdy_for_A",  64'(bus.rdy_for_A),  64'(ph[0] == P_OFFER));
      chk("rdy_for_B",  64'(bus.rdy_for_B),  64'(ph[1] == P_OFFER));
      chk("rdy_for_C",  64'(bus.rdy_for_C),  64'(ph[2] == P_OFFER));
      chk("A_done_ack", 64'(bus.A_done_ack), 64'(ack_e[0]));
      chk("B_done_ack", 64'(bus.B_done_ack), 64'(ack_e[1]));
      chk("C_done_ack", 64'(bus.C_done_ack), 64'(ack_e[2]));
      chk("sn_sel",     64'(bus.sn_sel),     64'(idx[0]));
      chk("cpu_sel",    64'(bus.cpu_sel),    64'(idx[1]));
      chk("fwd_sel",    64'(bus.fwd_sel),    64'(idx[2]));
      chk("buf_sel",    64'(bus.buf_sel),    64'(exp_buf_sel()));
      chk("free_cnt",   64'(bus.free_cnt),   64'(fq.size()));
      chk("cpu_q_cnt",  64'(bus.cpu_q_cnt),  64'(cq.size()));
      chk("fwd_q_cnt",  64'(bus.fwd_q_cnt),  64'(wq.size()));
      chk("drop_cnt",   64'(bus.drop_cnt),   64'(drops));
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;
   endtask

   int pa_tk, pa_dn, pb_tk, pb_acc, pb_rej, pc_tk, pc_dn;
   bit all_busy;

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();

      // Reset values, then first allocation one cycle after reset release.
      do_reset();
      chk("t0_free_cnt_rst", 64'(bus.free_cnt), 64'd4);
      chk("t0_buf_sel_rst",  64'(bus.buf_sel),  64'd0);
      step();
      chk("t1_rdy_for_A", 64'(bus.rdy_for_A), 64'd1);
      chk("t1_sn_sel",    64'(bus.sn_sel),    64'd0);
      chk("t1_buf_sel",   64'(bus.buf_sel),   64'h01);
      chk("t1_free_cnt",  64'(bus.free_cnt),  64'd3);

      // One buffer through snooper, CPU (accept) and forwarder.
      drive(1, 0, 0, 0, 0, 0, 0); step();
      drive(0, 1, 0, 0, 0, 0, 0); step();
      chk("t2_A_done_ack", 64'(bus.A_done_ack), 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0); step();
      chk("t2_A_ack_pulse", 64'(bus.A_done_ack), 64'd0);
      chk("t2_rdy_for_B",   64'(bus.rdy_for_B),  64'd1);
      chk("t2_cpu_sel",     64'(bus.cpu_sel),    64'd0);
      drive(0, 0, 1, 0, 0, 0, 0); step();
      drive(0, 0, 0, 1, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0); step();
      chk("t2_rdy_for_C", 64'(bus.rdy_for_C), 64'd1);
      chk("t2_fwd_sel",   64'(bus.fwd_sel),   64'd0);
      drive(0, 0, 0, 0, 0, 1, 0); step();
      drive(0, 0, 0, 0, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0, 0, 0); step();

      // CPU never takes its offer: the pool drains into the cpu queue.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0, 0, 0, 0, 0);
         step();
      end
`ifndef PN_CTRL_OVERWRITE_EN
      chk("t5_rdy_for_A_starved", 64'(bus.rdy_for_A), 64'd0);
      chk("t5_cpu_q_cnt",         64'(bus.cpu_q_cnt), 64'd3);
`endif

      // Bring every agent to BUSY, then reset with all dones asserted.
      do_reset();
      all_busy = 1'b0;
      for (int i = 0; i < 60 && !all_busy; i++) begin
         drive(1, (ph[1] == P_IDLE && cq.size() == 0), 1,
               (ph[2] == P_IDLE && wq.size() == 0), 0, 1, 0);
         step();
         all_busy = (ph[0] == P_BUSY) && (ph[1] == P_BUSY) && (ph[2] == P_BUSY);
      end
      chk("t6_reached_all_busy", 64'(all_busy), 64'd1);
      rst = 1'b1;
      drive(1, 1, 1, 1, 1, 1, 1);
      step();
      chk("t6_A_ack_on_rst", 64'(bus.A_done_ack), 64'd0);
      chk("t6_B_ack_on_rst", 64'(bus.B_done_ack), 64'd0);
      chk("t6_C_ack_on_rst", 64'(bus.C_done_ack), 64'd0);
      chk("t6_buf_sel_rst",  64'(bus.buf_sel),    64'd0);
      chk("t6_free_cnt_rst", 64'(bus.free_cnt),   64'd4);
      rst = 1'b0;

      // Randomized agents with per-phase probabilities, occasional mid-run reset.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 150 == 0) begin
            pa_tk  = int'($urandom_range(10, 100));
            pa_dn  = int'($urandom_range(10, 100));
            pb_tk  = int'($urandom_range(0, 100));
            pb_acc = int'($urandom_range(0, 90));
            pb_rej = int'($urandom_range(0, 60));
            pc_tk  = int'($urandom_range(0, 100));
            pc_dn  = int'($urandom_range(0, 90));
         end
         rst = ($urandom_range(0, 399) == 0);
         drive(pr(pa_tk), pr(pa_dn), pr(pb_tk), pr(pb_acc), pr(pb_rej), pr(pc_tk), pr(pc_dn));
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
